// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller and the stage registers.
//   state_e : controller FSM encoding (RUN / MEM_WAIT / FAULT)
//   REG_W   : default register-address width
//   ctrl_t  : control bundle driven into PC and the stage registers. The field
//             order fixes the bit positions (pc_write is the MSB, pc_sel the LSB).
//   CTRL_*  : canned bundles for each priority level
package pipe_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;      // [8] 0 = PC holds
    logic if_id_write;   // [7] 0 = IF/ID holds
    logic id_ex_hold;    // [6] 1 = ID/EX holds
    logic ex_mem_hold;   // [5] 1 = EX/MEM holds
    logic if_id_flush;   // [4] clear IF/ID to a bubble
    logic id_ex_flush;   // [3] clear ID/EX to a bubble
    logic ex_mem_flush;  // [2] clear EX/MEM to a bubble
    logic mem_wb_flush;  // [1] clear MEM/WB to a bubble
    logic pc_sel;        // [0] 1 = PC loads the JEQ target
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_RESET = '0;

  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};

  // Freeze the front end and EX/MEM while memory is busy; WB receives a bubble.
  localparam ctrl_t CTRL_MEM_WAIT = '{id_ex_hold: 1'b1, ex_mem_hold: 1'b1,
                                      mem_wb_flush: 1'b1, default: 1'b0};

  // Redirect fetch and kill the three instructions younger than the branch.
  localparam ctrl_t CTRL_TAKEN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                   id_ex_flush: 1'b1, ex_mem_flush: 1'b1, pc_sel: 1'b1,
                                   default: 1'b0};

  // Hold PC and IF/ID one cycle and insert a single bubble into EX.
  localparam ctrl_t CTRL_LOAD_USE = '{id_ex_flush: 1'b1, default: 1'b0};

  // Freeze everything; nothing moves until reset.
  localparam ctrl_t CTRL_FAULT = '{id_ex_hold: 1'b1, ex_mem_hold: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
//   master : datapath side - drives ID/EX/MEM status, receives controls
//   slave  : controller side - receives status, drives controls, fault,
//            stall count and the FSM state (debug visibility)
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = pipe_pkg::REG_W,
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  // Pipeline status
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use1;
  logic             id_use2;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             mem_jeq;
  logic             mem_zero;
  logic             mem_req;
  logic             mem_ready;

  // Controls
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_hold;
  logic             ex_mem_hold;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             pc_sel;
  logic             fault;
  logic [CNT_W-1:0] stall_count;
  state_e           state;

  modport master (
    output id_rs1, id_rs2, id_use1, id_use2, ex_mem_read, ex_rd,
           mem_jeq, mem_zero, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_hold, ex_mem_hold, if_id_flush,
           id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel, fault,
           stall_count, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use1, id_use2, ex_mem_read, ex_rd,
           mem_jeq, mem_zero, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_hold, ex_mem_hold, if_id_flush,
           id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel, fault,
           stall_count, state
  );

endinterface

// File: rtl/hazard_detect.sv
// Purely combinational hazard decode.
//   id_rs1_i/id_rs2_i, id_use1_i/id_use2_i : sources read by the ID instruction
//   ex_mem_read_i, ex_rd_i                  : load in EX and its destination
//   mem_jeq_i, mem_zero_i                   : JEQ resolution in MEM
//   load_use_o                              : ID needs a value the EX load has not produced
//   taken_o                                 : JEQ in MEM is taken
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use1_i,
  input  logic             id_use2_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             mem_jeq_i,
  input  logic             mem_zero_i,
  output logic             load_use_o,
  output logic             taken_o
);

  // Every register address takes part in the compare; no register is treated
  // as a hardwired zero, so a load to r0 still stalls a dependent reader.
  assign load_use_o = ex_mem_read_i &
                      ((id_use1_i & (ex_rd_i == id_rs1_i)) |
                       (id_use2_i & (ex_rd_i == id_rs2_i)));

  assign taken_o = mem_jeq_i & mem_zero_i;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard and sequencing controller for the five-stage pipeline.
//   clk     : pipeline clock
//   rst     : asynchronous, active-high reset
//   ctl_if  : slave side of pipe_hazard_ctrl_if (status in, controls out)
// Priority of the control bundle: FAULT > memory wait > taken JEQ > load-use > normal.
// Controls are combinational from state and inputs; state, wait counter,
// fault flag and stall counter are registered.
module pipe_hazard_ctrl #(
  parameter int REG_W   = pipe_pkg::REG_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave ctl_if
);
  import pipe_pkg::*;

  // Wide enough to hold TIMEOUT itself.
  localparam int              WAIT_W      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               load_use;
  logic               taken;
  logic               mem_wait;
  ctrl_t              ctrl;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs1_i      (ctl_if.id_rs1),
    .id_rs2_i      (ctl_if.id_rs2),
    .id_use1_i     (ctl_if.id_use1),
    .id_use2_i     (ctl_if.id_use2),
    .ex_mem_read_i (ctl_if.ex_mem_read),
    .ex_rd_i       (ctl_if.ex_rd),
    .mem_jeq_i     (ctl_if.mem_jeq),
    .mem_zero_i    (ctl_if.mem_zero),
    .load_use_o    (load_use),
    .taken_o       (taken)
  );

  assign mem_wait = ctl_if.mem_req & ~ctl_if.mem_ready;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and wait counter
  // ---------------------------------------------------------------------------
  // wait_q holds the number of memory-wait cycles already completed, so the
  // cycle in which it equals TIMEOUT is wait cycle TIMEOUT+1; still no ready
  // there means the wait has exceeded the limit.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          if (wait_q == TIMEOUT_CNT) begin
            state_d = FAULT;
          end else begin
            state_d = MEM_WAIT;
            wait_d  = wait_q + WAIT_W'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: control priority mux
  // ---------------------------------------------------------------------------
  // Reset forces the bundle to all-zero asynchronously so the pipeline is
  // frozen from the moment reset rises, not from the next edge.
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (state_q == FAULT) ctrl = CTRL_FAULT;
    else if (mem_wait)    ctrl = CTRL_MEM_WAIT;  // also wins over an illegal MemReq+MemJeq
    else if (taken)       ctrl = CTRL_TAKEN;     // load-use is moot: ID is being flushed
    else if (load_use)    ctrl = CTRL_LOAD_USE;
    if (rst)              ctrl = CTRL_RESET;
  end

  // ---------------------------------------------------------------------------
  // Sticky fault flag
  // ---------------------------------------------------------------------------
  assign fault_d = fault_q | (state_d == FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  // ---------------------------------------------------------------------------
  // Saturating stall counter: counts every cycle the PC is held. A taken
  // branch keeps pc_write high, so its flush cycle is not counted.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_d = stall_q;
    if (!ctrl.pc_write && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  // ---------------------------------------------------------------------------
  // Drive the interface
  // ---------------------------------------------------------------------------
  assign ctl_if.pc_write     = ctrl.pc_write;
  assign ctl_if.if_id_write  = ctrl.if_id_write;
  assign ctl_if.id_ex_hold   = ctrl.id_ex_hold;
  assign ctl_if.ex_mem_hold  = ctrl.ex_mem_hold;
  assign ctl_if.if_id_flush  = ctrl.if_id_flush;
  assign ctl_if.id_ex_flush  = ctrl.id_ex_flush;
  assign ctl_if.ex_mem_flush = ctrl.ex_mem_flush;
  assign ctl_if.mem_wb_flush = ctrl.mem_wb_flush;
  assign ctl_if.pc_sel       = ctrl.pc_sel;
  assign ctl_if.fault        = fault_q;
  assign ctl_if.stall_count  = stall_q;
  assign ctl_if.state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Control bundle is observed as a 9-bit vector in the order
// {pc_write, if_id_write, id_ex_hold, ex_mem_hold, if_id_flush,
//  id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel}.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam logic [8:0] EXP_RESET    = 9'b000000000;
  localparam logic [8:0] EXP_NORMAL   = 9'b110000000;
  localparam logic [8:0] EXP_LOAD_USE = 9'b000001000;
  localparam logic [8:0] EXP_TAKEN    = 9'b110011101;
  localparam logic [8:0] EXP_MEM_WAIT = 9'b001100010;
  localparam logic [8:0] EXP_FAULT    = 9'b001100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(3), .CNT_W(4)) bus ();

  pipe_hazard_ctrl #(.REG_W(3), .TIMEOUT(4), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl_if (bus.slave)
  );

  logic [8:0] ctrl_obs;
  assign ctrl_obs = {bus.pc_write, bus.if_id_write, bus.id_ex_hold, bus.ex_mem_hold,
                     bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
                     bus.mem_wb_flush, bus.pc_sel};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use1 = 1'b0; bus.id_use2 = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rd = '0;
    bus.mem_jeq = 1'b0; bus.mem_zero = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  // Short reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();

    // ---- reset state ----
    #2;
    check("reset_ctrl", 32'(ctrl_obs), 32'(EXP_RESET));
    check("reset_state", 32'(bus.state), 32'(RUN));
    check("reset_stall", 32'(bus.stall_count), 0);
    check("reset_fault", 32'(bus.fault), 0);
    step();
    rst = 1'b0;
    #1;
    check("idle_normal", 32'(ctrl_obs), 32'(EXP_NORMAL));

    // ---- load-use on rs1: one bubble ----
    bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd3; bus.id_rs1 = 3'd3; bus.id_use1 = 1'b1;
    #1;
    check("lu_rs1_ctrl", 32'(ctrl_obs), 32'(EXP_LOAD_USE));
    step();
    check("lu_rs1_stall", 32'(bus.stall_count), 1);
    bus.ex_mem_read = 1'b0;  // bubble now in EX
    #1;
    check("lu_after_normal", 32'(ctrl_obs), 32'(EXP_NORMAL));
    step();
    check("lu_after_stall", 32'(bus.stall_count), 1);

    // ---- same registers but rs1 not used: no stall ----
    bus.ex_mem_read = 1'b1; bus.id_use1 = 1'b0;
    #1;
    check("nouse_ctrl", 32'(ctrl_obs), 32'(EXP_NORMAL));
    // different destination: no stall
    bus.id_use1 = 1'b1; bus.ex_rd = 3'd4;
    #1;
    check("rd_mismatch_ctrl", 32'(ctrl_obs), 32'(EXP_NORMAL));
    // match through rs2 only
    bus.id_use1 = 1'b1; bus.id_rs1 = 3'd5; bus.id_use2 = 1'b1; bus.id_rs2 = 3'd4;
    #1;
    check("lu_rs2_ctrl", 32'(ctrl_obs), 32'(EXP_LOAD_USE));
    step();
    check("lu_rs2_stall", 32'(bus.stall_count), 2);

    // ---- taken JEQ with a simultaneous load-use ----
    bus.mem_jeq = 1'b1; bus.mem_zero = 1'b1;
    #1;
    check("taken_ctrl", 32'(ctrl_obs), 32'(EXP_TAKEN));
    step();
    check("taken_stall", 32'(bus.stall_count), 2);
    // JEQ not taken: load-use takes over again
    bus.mem_zero = 1'b0;
    #1;
    check("jeq_nt_ctrl", 32'(ctrl_obs), 32'(EXP_LOAD_USE));
    clear_inputs();

    // ---- memory latency 4: three stall cycles ----
    pulse_reset();
    check("rst_pulse_stall", 32'(bus.stall_count), 0);
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("mw%0d_ctrl", i), 32'(ctrl_obs), 32'(EXP_MEM_WAIT));
      step();
      check($sformatf("mw%0d_state", i), 32'(bus.state), 32'(MEM_WAIT));
    end
    bus.mem_ready = 1'b1;
    #1;
    check("mw_release_ctrl", 32'(ctrl_obs), 32'(EXP_NORMAL));
    step();
    check("mw_release_state", 32'(bus.state), 32'(RUN));
    check("mw_stall", 32'(bus.stall_count), 3);
    clear_inputs();

    // ---- timeout: five wait cycles then FAULT ----
    // First cycle also carries an illegal JEQ; memory wait must win.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.mem_jeq = 1'b1; bus.mem_zero = 1'b1;
    #1;
    check("mw_vs_jeq_ctrl", 32'(ctrl_obs), 32'(EXP_MEM_WAIT));
    bus.mem_jeq = 1'b0; bus.mem_zero = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("to_wait%0d_fault", i), 32'(bus.fault), 0);
    end
    check("to_wait4_state", 32'(bus.state), 32'(MEM_WAIT));
    step();
    check("to_state", 32'(bus.state), 32'(FAULT));
    check("to_fault", 32'(bus.fault), 1);
    check("to_ctrl", 32'(ctrl_obs), 32'(EXP_FAULT));
    bus.mem_ready = 1'b1;  // late completion does not clear the fault
    step();
    check("to_sticky_state", 32'(bus.state), 32'(FAULT));
    check("to_sticky_ctrl", 32'(ctrl_obs), 32'(EXP_FAULT));
    pulse_reset();
    check("to_rst_fault", 32'(bus.fault), 0);
    check("to_rst_state", 32'(bus.state), 32'(RUN));
    check("to_rst_stall", 32'(bus.stall_count), 0);
    clear_inputs();

    // ---- saturation: 20 consecutive load-use stall cycles ----
    bus.ex_mem_read = 1'b1; bus.ex_rd = 3'd0; bus.id_rs1 = 3'd0; bus.id_use1 = 1'b1;
    for (int i = 0; i < 14; i++) step();
    check("sat_14", 32'(bus.stall_count), 14);
    for (int i = 0; i < 6; i++) step();
    check("sat_20", 32'(bus.stall_count), 15);
    check("sat_ctrl", 32'(ctrl_obs), 32'(EXP_LOAD_USE));
    clear_inputs();

    // ---- asynchronous reset in the middle of a memory wait ----
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    step();
    step();
    check("amid_state", 32'(bus.state), 32'(MEM_WAIT));
    #2;
    rst = 1'b1;
    #1;
    check("amid_rst_ctrl", 32'(ctrl_obs), 32'(EXP_RESET));
    check("amid_rst_state", 32'(bus.state), 32'(RUN));
    check("amid_rst_stall", 32'(bus.stall_count), 0);
    #1;
    rst = 1'b0;
    #1;
    check("amid_post_ctrl", 32'(ctrl_obs), 32'(EXP_MEM_WAIT));
    // wait count restarts from zero: four more edges are still short of FAULT
    for (int i = 0; i < 4; i++) step();
    check("amid_no_carry_state", 32'(bus.state), 32'(MEM_WAIT));
    check("amid_no_carry_fault", 32'(bus.fault), 0);
    clear_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
